mux4to1_case_top: RTL and testbench
===================================

MUX4TO1_CASE_TOP -- requirements
Module: mux4to1_case

Interface
REQ-001 Parameter WIDTH, default 1, gives the bit width of each data lane and of every data output.
REQ-002 Port clk, input, 1 bit: single clock; all registers update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port sel, input, 2 bits: lane select; sel[1] is the MSB.
REQ-005 Port in, input, 4*WIDTH bits: four lanes; lane k occupies in[k*WIDTH +: WIDTH].
REQ-006 Port out, output, WIDTH bits: combinational mux result.
REQ-007 Port out_q, output, WIDTH bits: out registered by one clk cycle.
REQ-008 Port mismatch, output, 1 bit: registered flag, high when the internal implementations disagree.

Function
REQ-009 out SHALL equal lane sel combinationally in all cases: sel=0 gives lane 0, 1 gives lane 1, 2 gives lane 2, 3 gives lane 3.
REQ-010 out SHALL have zero-cycle latency: any change on sel or in propagates within the same delta cycle, with no clock dependence.
REQ-011 The block SHALL compute three internal results from the same sel and in:
- c_out: case statement on sel.
- i_out: if/else-if chain on sel.
- g_out: tree of three mux2to1 instances (sel[0] at the first level, sel[1] at the second).
REQ-012 out SHALL be driven from c_out.
REQ-013 For any sel containing X or Z, c_out and i_out SHALL drive all zeros (default branch).
REQ-014 out_q SHALL load out on every rising clk edge while rst_n is high.
REQ-015 mismatch SHALL load (c_out != i_out) || (c_out != g_out) on every rising clk edge, using 2-state comparison with X treated as a mismatch.
REQ-016 mismatch SHALL be non-sticky: it SHALL clear on the first edge after the three results agree.
REQ-017 In correct operation, mismatch SHALL always read 0 after reset.
REQ-018 The block SHALL have no enable, no handshake and no internal state other than out_q and mismatch.

Reset
REQ-019 When rst_n goes low, out_q and mismatch SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-020 While rst_n is low, out SHALL still follow sel and in combinationally.
REQ-021 Registers SHALL resume loading on the first rising clk edge after rst_n returns high.
REQ-022 If rst_n is asserted mid-operation, it SHALL discard any pending value.

Structure
REQ-023 Lane count (4) and select width (2) SHALL be defined as constants in the shared package mux_pkg.
REQ-024 WIDTH SHALL remain a module parameter and SHALL NOT be placed in the package.
REQ-025 Exactly one sub-module, mux2to1, SHALL exist:
- ports a, b, s, y, each WIDTH bits except s (1 bit);
- y = s ? b : a.
REQ-026 The case, if and instance variants SHALL live inside mux4to1_case.
REQ-027 mux4to1_if and mux4to1_inst SHALL be thin wrappers that expose i_out and g_out respectively on out, with an identical port list.

Verification
REQ-028 With WIDTH=1, apply sel=3, in=4'b1000. Required: out=1, then out_q=1 one edge later.
REQ-029 Apply sel=2, in=4'b1001. Required: out=0.
REQ-030 Walk sel through 1, 2, 3 with these inputs:
- sel=1, in=4'b1010: required out=1;
- sel=2, in=4'b0100: required out=1;
- sel=3, in=4'b1111: required out=1.
REQ-031 Run an exhaustive sweep of all 64 sel/in combinations across mux4to1_case, mux4to1_if and mux4to1_inst. Required: all three outputs equal in[sel], and mismatch stays 0.
REQ-032 Assert rst_n low between clock edges while out_q=1. Required: out_q and mismatch drop to 0 immediately, while out keeps tracking.
REQ-033 Drive sel=2'bx. Required: out=0, and mismatch=1 on the next edge.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and types for the 4:1 mux slice
//
// Purpose:
//    Holds the lane count, select width and the variant selector used by
//    mux4to1_case and its wrappers. Data width deliberately stays a
//    per-instance module parameter and is not defined here.
//
// Contents:
//    NUM_LANES  - number of data lanes (4)
//    SEL_W      - width of the lane select (2)
//    variant_e  - which internal implementation drives the out port

package mux_pkg;

   localparam int NUM_LANES = 4;
   localparam int SEL_W     = 2;

   // Picks which of the three internal results is exposed on out.
   typedef enum logic [1:0] {
      VAR_CASE = 2'd0,
      VAR_IF   = 2'd1,
      VAR_INST = 2'd2
   } variant_e;

endpackage : mux_pkg

// File: rtl/mux2to1.sv
// rtl/mux2to1.sv - two-input multiplexer leaf cell
//
// Purpose:
//    Building block for the instance-tree variant of the 4:1 mux.
//
// Ports:
//    a  - input,  WIDTH bits: selected when s = 0
//    b  - input,  WIDTH bits: selected when s = 1
//    s  - input,  1 bit:      select
//    y  - output, WIDTH bits: s ? b : a

module mux2to1 #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output logic [WIDTH-1:0] y
);

   // The conditional operator is kept on purpose: an unknown s merges
   // a and b, which lets the parent flag an undefined select.
   assign y = s ? b : a;

endmodule : mux2to1

// File: rtl/mux4to1_case.sv
// rtl/mux4to1_case.sv - 4:1 mux built three ways with a cross-check flag
//
// Purpose:
//    Computes the selected lane with a case statement (c_out), an
//    if/else-if chain (i_out) and a tree of mux2to1 cells (g_out). One
//    of them, chosen by VARIANT, drives out. out is also registered, and
//    a registered flag reports any disagreement between the three.
//
// Parameters:
//    WIDTH    - bits per data lane
//    VARIANT  - VAR_CASE (default), VAR_IF or VAR_INST
//
// Ports:
//    clk       - input,  1 bit:            rising-edge clock
//    rst_n     - input,  1 bit:            asynchronous active-low reset
//    sel       - input,  SEL_W bits:       lane select
//    in        - input,  NUM_LANES*WIDTH:  lane k at in[k*WIDTH +: WIDTH]
//    out       - output, WIDTH bits:       combinational mux result
//    out_q     - output, WIDTH bits:       out delayed by one clk cycle
//    mismatch  - output, 1 bit:            registered implementation disagreement

module mux4to1_case
   import mux_pkg::*;
#(
   parameter int       WIDTH   = 1,
   parameter variant_e VARIANT = VAR_CASE
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [SEL_W-1:0]           sel,
   input  logic [NUM_LANES*WIDTH-1:0] in,
   output logic [WIDTH-1:0]           out,
   output logic [WIDTH-1:0]           out_q,
   output logic                       mismatch
);

   logic [WIDTH-1:0] lane [NUM_LANES];
   logic [WIDTH-1:0] c_out;
   logic [WIDTH-1:0] i_out;
   logic [WIDTH-1:0] g_out;
   logic [WIDTH-1:0] g_lo;
   logic [WIDTH-1:0] g_hi;

   logic [WIDTH-1:0] out_q_d;
   logic [WIDTH-1:0] out_q_q;
   logic             mismatch_d;
   logic             mismatch_q;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      assign lane[k] = in[k*WIDTH +: WIDTH];
   end

   // Case variant: an unknown select matches no item and falls into the
   // default, so the result is all zeros rather than X.
   always_comb begin
      c_out = '0;
      case (sel)
         2'd0:    c_out = lane[0];
         2'd1:    c_out = lane[1];
         2'd2:    c_out = lane[2];
         2'd3:    c_out = lane[3];
         default: c_out = '0;
      endcase
   end

   // If-chain variant: every value is tested explicitly so that an
   // unknown select reaches the final else and also yields zeros.
   always_comb begin
      i_out = '0;
      if (sel == 2'd0) begin
         i_out = lane[0];
      end else if (sel == 2'd1) begin
         i_out = lane[1];
      end else if (sel == 2'd2) begin
         i_out = lane[2];
      end else if (sel == 2'd3) begin
         i_out = lane[3];
      end else begin
         i_out = '0;
      end
   end

   // Instance-tree variant: sel[0] picks within each pair, sel[1] picks
   // between the pairs.
   mux2to1 #(.WIDTH(WIDTH)) u_mux_lo (
      .a (lane[0]),
      .b (lane[1]),
      .s (sel[0]),
      .y (g_lo)
   );

   mux2to1 #(.WIDTH(WIDTH)) u_mux_hi (
      .a (lane[2]),
      .b (lane[3]),
      .s (sel[0]),
      .y (g_hi)
   );

   mux2to1 #(.WIDTH(WIDTH)) u_mux_top (
      .a (g_lo),
      .b (g_hi),
      .s (sel[1]),
      .y (g_out)
   );

   if (VARIANT == VAR_IF) begin : g_out_if
      assign out = i_out;
   end else if (VARIANT == VAR_INST) begin : g_out_inst
      assign out = g_out;
   end else begin : g_out_case
      assign out = c_out;
   end

   // Case-equality makes any X/Z difference count as a disagreement; with
   // an undefined select the tree output goes X while c_out is zero.
   assign mismatch_d = (c_out !== i_out) || (c_out !== g_out);
   assign out_q_d    = out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q_q    <= '0;
         mismatch_q <= 1'b0;
      end else begin
         out_q_q    <= out_q_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign out_q    = out_q_q;
   assign mismatch = mismatch_q;

endmodule : mux4to1_case

// File: rtl/mux4to1_if.sv
// rtl/mux4to1_if.sv - 4:1 mux exposing the if-chain result on out
//
// Purpose:
//    Thin wrapper around mux4to1_case with the if/else-if result on out.
//
// Ports:
//    clk, rst_n, sel, in, out, out_q, mismatch - as mux4to1_case

module mux4to1_if
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [SEL_W-1:0]           sel,
   input  logic [NUM_LANES*WIDTH-1:0] in,
   output logic [WIDTH-1:0]           out,
   output logic [WIDTH-1:0]           out_q,
   output logic                       mismatch
);

   mux4to1_case #(
      .WIDTH   (WIDTH),
      .VARIANT (VAR_IF)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .sel      (sel),
      .in       (in),
      .out      (out),
      .out_q    (out_q),
      .mismatch (mismatch)
   );

endmodule : mux4to1_if

// File: rtl/mux4to1_inst.sv
// rtl/mux4to1_inst.sv - 4:1 mux exposing the mux2to1-tree result on out
//
// Purpose:
//    Thin wrapper around mux4to1_case with the instance-tree result on out.
//
// Ports:
//    clk, rst_n, sel, in, out, out_q, mismatch - as mux4to1_case

module mux4to1_inst
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [SEL_W-1:0]           sel,
   input  logic [NUM_LANES*WIDTH-1:0] in,
   output logic [WIDTH-1:0]           out,
   output logic [WIDTH-1:0]           out_q,
   output logic                       mismatch
);

   mux4to1_case #(
      .WIDTH   (WIDTH),
      .VARIANT (VAR_INST)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .sel      (sel),
      .in       (in),
      .out      (out),
      .out_q    (out_q),
      .mismatch (mismatch)
   );

endmodule : mux4to1_inst

// File: rtl/mux4to1_case_top.sv
// rtl/mux4to1_case_top.sv - top level of the 4:1 mux slice
//
// Purpose:
//    Integration top; the case-statement variant drives out.
//
// Ports:
//    clk       - input,  1 bit:            rising-edge clock
//    rst_n     - input,  1 bit:            asynchronous active-low reset
//    sel       - input,  SEL_W bits:       lane select
//    in        - input,  NUM_LANES*WIDTH:  four data lanes
//    out       - output, WIDTH bits:       combinational mux result
//    out_q     - output, WIDTH bits:       registered out
//    mismatch  - output, 1 bit:            registered implementation disagreement

module mux4to1_case_top
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [SEL_W-1:0]           sel,
   input  logic [NUM_LANES*WIDTH-1:0] in,
   output logic [WIDTH-1:0]           out,
   output logic [WIDTH-1:0]           out_q,
   output logic                       mismatch
);

   mux4to1_case #(
      .WIDTH   (WIDTH),
      .VARIANT (VAR_CASE)
   ) u_mux (
      .clk      (clk),
      .rst_n    (rst_n),
      .sel      (sel),
      .in       (in),
      .out      (out),
      .out_q    (out_q),
      .mismatch (mismatch)
   );

endmodule : mux4to1_case_top

// File: tb/tb_mux4to1_case_top.sv
// tb/tb_mux4to1_case_top.sv - directed self-checking bench for the 4:1 mux slice

module tb_mux4to1_case_top;

   typedef struct {
      logic [1:0] sel;
      logic [3:0] in;
      logic       exp_out;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [1:0] sel;
   logic [3:0] in;

   logic       out_c, out_q_c, mm_c;
   logic       out_i, out_q_i, mm_i;
   logic       out_g, out_q_g, mm_g;

   int checks = 0;
   int errors = 0;

   vec_t vecs [8];

   mux4to1_case_top #(.WIDTH(1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sel      (sel),
      .in       (in),
      .out      (out_c),
      .out_q    (out_q_c),
      .mismatch (mm_c)
   );

   mux4to1_if #(.WIDTH(1)) dut_if (
      .clk      (clk),
      .rst_n    (rst_n),
      .sel      (sel),
      .in       (in),
      .out      (out_i),
      .out_q    (out_q_i),
      .mismatch (mm_i)
   );

   mux4to1_inst #(.WIDTH(1)) dut_inst (
      .clk      (clk),
      .rst_n    (rst_n),
      .sel      (sel),
      .in       (in),
      .out      (out_g),
      .out_q    (out_q_g),
      .mismatch (mm_g)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: end of test not reached, got timeout required finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic probe;
      logic four_state;
      logic [3:0] v;
      logic       exp_bit;

      probe      = 1'bx;
      four_state = $isunknown(probe);

      vecs[0] = '{sel: 2'd3, in: 4'b1000, exp_out: 1'b1};
      vecs[1] = '{sel: 2'd2, in: 4'b1001, exp_out: 1'b0};
      vecs[2] = '{sel: 2'd1, in: 4'b1010, exp_out: 1'b1};
      vecs[3] = '{sel: 2'd2, in: 4'b0100, exp_out: 1'b1};
      vecs[4] = '{sel: 2'd3, in: 4'b1111, exp_out: 1'b1};
      vecs[5] = '{sel: 2'd0, in: 4'b0001, exp_out: 1'b1};
      vecs[6] = '{sel: 2'd0, in: 4'b1110, exp_out: 1'b0};
      vecs[7] = '{sel: 2'd1, in: 4'b1101, exp_out: 1'b0};

      // Reset state, and out tracking while reset is held.
      rst_n = 1'b0;
      sel   = 2'd0;
      in    = 4'b0000;
      #1;
      check("reset_out_q", out_q_c, 0);
      check("reset_mismatch", mm_c, 0);
      sel = 2'd3;
      in  = 4'b1000;
      #1;
      check("out_in_reset", out_c, 1);
      tick();
      check("out_q_held_in_reset", out_q_c, 0);
      rst_n = 1'b1;

      // Directed vectors: combinational out on all variants, then the
      // registered value one edge later with no disagreement.
      for (int i = 0; i < 8; i++) begin
         sel = vecs[i].sel;
         in  = vecs[i].in;
         #1;
         check($sformatf("vec%0d_out_case", i), out_c, vecs[i].exp_out);
         check($sformatf("vec%0d_out_if", i), out_i, vecs[i].exp_out);
         check($sformatf("vec%0d_out_inst", i), out_g, vecs[i].exp_out);
         tick();
         check($sformatf("vec%0d_out_q", i), out_q_c, vecs[i].exp_out);
         check($sformatf("vec%0d_mismatch", i), mm_c, 0);
      end

      // Exhaustive sweep of every select / input combination.
      for (int s = 0; s < 4; s++) begin
         for (int d = 0; d < 16; d++) begin
            v       = 4'(d);
            exp_bit = v[s];
            sel     = 2'(s);
            in      = v;
            #1;
            check($sformatf("sweep_s%0d_in%0h_case", s, d), out_c, exp_bit);
            check($sformatf("sweep_s%0d_in%0h_if", s, d), out_i, exp_bit);
            check($sformatf("sweep_s%0d_in%0h_inst", s, d), out_g, exp_bit);
            tick();
            check($sformatf("sweep_s%0d_in%0h_out_q", s, d), out_q_c, exp_bit);
            check($sformatf("sweep_s%0d_in%0h_mm_case", s, d), mm_c, 0);
            check($sformatf("sweep_s%0d_in%0h_mm_if", s, d), mm_i, 0);
            check($sformatf("sweep_s%0d_in%0h_mm_inst", s, d), mm_g, 0);
         end
      end

      // Asynchronous reset between edges discards the loaded value.
      sel = 2'd3;
      in  = 4'b1000;
      tick();
      check("pre_reset_out_q", out_q_c, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_out_q", out_q_c, 0);
      check("async_reset_mismatch", mm_c, 0);
      in = 4'b0000;
      #1;
      check("reset_track_low", out_c, 0);
      in = 4'b1000;
      #1;
      check("reset_track_high", out_c, 1);
      tick();
      check("reset_hold_out_q", out_q_c, 0);
      rst_n = 1'b1;
      tick();
      check("reset_resume_out_q", out_q_c, 1);

      // Undefined select: case and if variants fall to zeros, the tree
      // goes unknown, so the flag rises on the next edge. A two-state
      // simulator resolves the X to a real select and everything agrees.
      in  = 4'b1110;
      sel = 2'bxx;
      #1;
      exp_bit = four_state ? 1'b0 : in[sel];
      check("xsel_out_case", out_c, exp_bit);
      check("xsel_out_if", out_i, exp_bit);
      tick();
      check("xsel_mismatch", mm_c, four_state ? 1 : 0);
      sel = 2'd0;
      tick();
      check("xsel_mismatch_clears", mm_c, 0);
      check("xsel_out_q_after", out_q_c, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mux4to1_case_top
